// File: rtl/reg_file_wb.sv
// Write-back register file: 2 combinational read ports, 1 write port, post-reset clear sweep.
// Optional write-through bypass enabled by defining REG_FILE_BYPASS_EN.
module reg_file_wb #(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned ADDR_W = 5
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    input  logic [ADDR_W-1:0] rd_addr1,
    input  logic [ADDR_W-1:0] rd_addr2,
    output logic [DATA_W-1:0] rd_data1,
    output logic [DATA_W-1:0] rd_data2,
    output logic              busy,
    output logic              wr_ack
);
    localparam int unsigned DEPTH = 2 ** ADDR_W;
    localparam int unsigned CNT_W = ADDR_W + 1;

    localparam logic [0:0] ST_CLEAR = 1'b0;
    localparam logic [0:0] ST_READY = 1'b1;

    logic [0:0]        state_q, state_d;
    logic [CNT_W-1:0]  clr_cnt_q, clr_cnt_d;
    logic              wr_ack_q, wr_ack_d;

    logic              mem_we_c;
    logic [ADDR_W-1:0] mem_waddr_c;
    logic [DATA_W-1:0] mem_wdata_c;
    logic              wr_accept_c;

    logic [DATA_W-1:0] mem_q [DEPTH];

    assign busy        = (state_q == ST_CLEAR);
    assign wr_accept_c = (state_q == ST_READY) && wr_en && (wr_addr != '0);
    assign wr_ack      = wr_ack_q;

    // Next state plus the single shared array write port (reset, clear sweep, or WB write).
    always_comb begin
        state_d     = state_q;
        clr_cnt_d   = clr_cnt_q;
        wr_ack_d    = 1'b0;
        mem_we_c    = 1'b0;
        mem_waddr_c = wr_addr;
        mem_wdata_c = wr_data;
        if (reset) begin
            state_d     = ST_CLEAR;
            clr_cnt_d   = '0;
            mem_we_c    = 1'b1;
            mem_waddr_c = '0;
            mem_wdata_c = '0;
        end else begin
            case (state_q)
                ST_CLEAR: begin
                    mem_we_c    = 1'b1;
                    mem_waddr_c = clr_cnt_q[ADDR_W-1:0];
                    mem_wdata_c = '0;
                    clr_cnt_d   = clr_cnt_q + CNT_W'(1);
                    if (clr_cnt_q[ADDR_W-1:0] == '1) begin
                        state_d = ST_READY;
                    end
                end
                ST_READY: begin
                    if (wr_accept_c) begin
                        mem_we_c = 1'b1;
                        wr_ack_d = 1'b1;
                    end
                end
                default: state_d = ST_CLEAR;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        state_q   <= state_d;
        clr_cnt_q <= clr_cnt_d;
        wr_ack_q  <= wr_ack_d;
    end

    always_ff @(posedge clk) begin
        if (mem_we_c) begin
            mem_q[mem_waddr_c] <= mem_wdata_c;
        end
    end

    // Read ports: forced to zero for r0 and while the sweep is in progress.
    always_comb begin
        rd_data1 = mem_q[rd_addr1];
        rd_data2 = mem_q[rd_addr2];
`ifdef REG_FILE_BYPASS_EN
        if (wr_accept_c && (rd_addr1 == wr_addr)) begin
            rd_data1 = wr_data;
        end
        if (wr_accept_c && (rd_addr2 == wr_addr)) begin
            rd_data2 = wr_data;
        end
`else
`endif
        if (busy || (rd_addr1 == '0)) begin
            rd_data1 = '0;
        end
        if (busy || (rd_addr2 == '0)) begin
            rd_data2 = '0;
        end
    end

endmodule

// File: tb/tb_reg_file_wb.sv
// Self-checking bench for reg_file_wb: clear sweep, writes, r0, busy drops, restart, bypass.
module tb_reg_file_wb;
    logic        clk = 1'b0;
    logic        reset;
    logic        wr_en;
    logic [4:0]  wr_addr;
    logic [31:0] wr_data;
    logic [4:0]  rd_addr1, rd_addr2;
    logic [31:0] rd_data1, rd_data2;
    logic        busy, wr_ack;

    int total = 0;
    int bad   = 0;

    typedef struct {
        logic        we;
        logic [4:0]  wa;
        logic [31:0] wd;
        logic [4:0]  ra1;
        logic [4:0]  ra2;
        logic [31:0] e1;
        logic [31:0] e2;
        logic        eack;
    } vec_t;

    typedef struct {
        string       name;
        logic [31:0] val;
    } exp_t;

    exp_t ack_q[$];
    vec_t tbl[9];

    reg_file_wb #(.DATA_W(32), .ADDR_W(5)) dut (
        .clk      (clk),
        .reset    (reset),
        .wr_en    (wr_en),
        .wr_addr  (wr_addr),
        .wr_data  (wr_data),
        .rd_addr1 (rd_addr1),
        .rd_addr2 (rd_addr2),
        .rd_data1 (rd_data1),
        .rd_data2 (rd_data2),
        .busy     (busy),
        .wr_ack   (wr_ack)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    task automatic do_write(input logic [4:0] a, input logic [31:0] d);
        wr_en = 1'b1; wr_addr = a; wr_data = d;
        tick();
        wr_en = 1'b0;
    endtask

    // Runs until busy falls (bounded); optionally injects a write at clear cycle inj.
    task automatic clear_count(input int inj, output int n);
        n = 0;
        rd_addr1 = 5'd31;
        while (busy === 1'b1 && n < 100) begin
            if (n == inj) begin
                wr_en = 1'b1; wr_addr = 5'd3; wr_data = 32'hAAAA5555;
            end else begin
                wr_en = 1'b0;
            end
            @(negedge clk);
            if (n == 5) chk("rd_zero_while_busy", rd_data1, 32'h0);
            tick();
            if (n == inj) chk("ack_write_during_clear", 32'(wr_ack), 32'h0);
            n++;
        end
        wr_en = 1'b0;
    endtask

    task automatic pulse_reset(input int cycles);
        reset = 1'b1;
        repeat (cycles) tick();
        reset = 1'b0;
    endtask

    task automatic check_all_zero(input string tag);
        for (int i = 0; i < 32; i++) begin
            rd_addr1 = 5'(i);
            rd_addr2 = 5'(31 - i);
            @(negedge clk);
            chk(tag, rd_data1, 32'h0);
            chk(tag, rd_data2, 32'h0);
            tick();
        end
    endtask

    task automatic preload();
        for (int i = 1; i < 32; i++) begin
            do_write(5'(i), $urandom | 32'h1);
        end
    endtask

    initial begin
        int n;
        logic [31:0] exp_byp;

        tbl[0] = '{1'b1, 5'd5,  32'hDEADBEEF, 5'd1,  5'd2,  32'h0,        32'h0,        1'b1};
        tbl[1] = '{1'b1, 5'd31, 32'h12345678, 5'd5,  5'd2,  32'hDEADBEEF, 32'h0,        1'b1};
        tbl[2] = '{1'b0, 5'd0,  32'h0,        5'd5,  5'd31, 32'hDEADBEEF, 32'h12345678, 1'b0};
        tbl[3] = '{1'b1, 5'd0,  32'hFFFFFFFF, 5'd0,  5'd5,  32'h0,        32'hDEADBEEF, 1'b0};
        tbl[4] = '{1'b0, 5'd0,  32'h0,        5'd0,  5'd0,  32'h0,        32'h0,        1'b0};
        tbl[5] = '{1'b1, 5'd9,  32'h00000001, 5'd31, 5'd31, 32'h12345678, 32'h12345678, 1'b1};
        tbl[6] = '{1'b1, 5'd9,  32'hCAFEF00D, 5'd10, 5'd31, 32'h0,        32'h12345678, 1'b1};
        tbl[7] = '{1'b0, 5'd9,  32'h55555555, 5'd9,  5'd9,  32'hCAFEF00D, 32'hCAFEF00D, 1'b0};
        tbl[8] = '{1'b0, 5'd0,  32'h0,        5'd9,  5'd5,  32'hCAFEF00D, 32'hDEADBEEF, 1'b0};

        reset = 1'b1; wr_en = 1'b0; wr_addr = '0; wr_data = '0;
        rd_addr1 = 5'd5; rd_addr2 = 5'd31;
        tick(); tick();
        chk("reset_busy", 32'(busy), 32'h1);
        chk("reset_wr_ack", 32'(wr_ack), 32'h0);
        chk("reset_rd1", rd_data1, 32'h0);
        chk("reset_rd2", rd_data2, 32'h0);

        reset = 1'b0;
        clear_count(-1, n);
        chk("first_clear_len", 32'(n), 32'd32);

        // Preload, then reset for one cycle with a write injected at clear cycle 10.
        preload();
        pulse_reset(1);
        clear_count(10, n);
        chk("clear_len_after_preload", 32'(n), 32'd32);
        check_all_zero("zero_after_clear");

        // Table vectors: read expectations checked mid-cycle, wr_ack via scoreboard after the edge.
        for (int i = 0; i < 9; i++) begin
            wr_en = tbl[i].we; wr_addr = tbl[i].wa; wr_data = tbl[i].wd;
            rd_addr1 = tbl[i].ra1; rd_addr2 = tbl[i].ra2;
            ack_q.push_back('{$sformatf("vec%0d_wr_ack", i), 32'(tbl[i].eack)});
            @(negedge clk);
            chk($sformatf("vec%0d_rd1", i), rd_data1, tbl[i].e1);
            chk($sformatf("vec%0d_rd2", i), rd_data2, tbl[i].e2);
            tick();
            if (ack_q.size() > 0) begin
                exp_t e;
                e = ack_q.pop_front();
                chk(e.name, 32'(wr_ack), e.val);
            end
        end
        wr_en = 1'b0;

        // Same-cycle read of the register being written.
        do_write(5'd7, 32'h1);
        wr_en = 1'b1; wr_addr = 5'd7; wr_data = 32'h2; rd_addr1 = 5'd7; rd_addr2 = 5'd7;
`ifdef REG_FILE_BYPASS_EN
        exp_byp = 32'h2;
`else
        exp_byp = 32'h1;
`endif
        @(negedge clk);
        chk("same_cycle_rd1", rd_data1, exp_byp);
        chk("same_cycle_rd2", rd_data2, exp_byp);
        tick();
        wr_en = 1'b0;
        chk("same_cycle_ack", 32'(wr_ack), 32'h1);
        @(negedge clk);
        chk("next_cycle_rd1", rd_data1, 32'h2);

        // Reset in mid-clear restarts the full sweep.
        preload();
        pulse_reset(1);
        repeat (20) tick();
        chk("busy_mid_clear", 32'(busy), 32'h1);
        pulse_reset(1);
        clear_count(-1, n);
        chk("clear_len_after_restart", 32'(n), 32'd32);
        check_all_zero("zero_after_restart");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
